// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//
// Receive buffer that sits directly behind uart_rx. Every single-cycle
// in_valid pulse carries one word into a DEPTH-entry circular buffer. The
// buffer is presented to the system as a show-ahead valid/ready stream, so
// the consumer sees the oldest word on out_data whenever out_valid is high.
// The block also keeps a sticky overflow flag and, optionally, a saturating
// count of uart_rx error episodes.
//
// Optional feature macro: UART_RX_FIFO_ERR_COUNT_EN
//   defined   : in_error is registered and each rising edge increments
//               err_count. The count saturates at 2^ERR_WIDTH-1.
//   undefined : no error logic is built, err_count is tied to 0 and
//               in_error is ignored.
//   The FIFO data path is identical in both builds.
//
// Ports
//   clk           in   system clock, single domain
//   rst_n         in   synchronous reset, active low
//   in_valid      in   one-cycle pulse, one word from uart_rx
//   in_data       in   uart_rx data, sampled only when in_valid=1
//   in_error      in   uart_rx error_detected level
//   out_valid     out  head of FIFO holds a word
//   out_data      out  head word, forced to 0 when out_valid=0
//   out_ready     in   consumer takes the head when out_valid&out_ready
//   flush         in   discard every stored word
//   clear_status  in   clear overflow and err_count
//   count         out  number of stored words, 0..DEPTH
//   empty/full    out  count==0 / count==DEPTH
//   almost_full   out  count >= AFULL_LEVEL
//   overflow      out  sticky, a word was dropped while full
//   err_count     out  saturating count of in_error rising edges
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 16,
  parameter int AFULL_LEVEL = DEPTH - 2,
  parameter int ERR_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_error,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  out_data,
  input  logic                   out_ready,
  input  logic                   flush,
  input  logic                   clear_status,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   almost_full,
  output logic                   overflow,
  output logic [ERR_WIDTH-1:0]   err_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_AFULL = CW'(AFULL_LEVEL);

  // Storage and bookkeeping. The memory itself carries no reset: only the
  // pointers and count decide which entries are meaningful.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_overflow;

  logic w_not_empty;
  logic w_is_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_not_empty = (r_count != '0);
  assign w_is_full   = (r_count == C_DEPTH);

  // A flush cancels both sides of the handshake in its cycle. The incoming
  // word during a flush is simply discarded and is not an overflow.
  assign w_pop  = w_not_empty & out_ready & ~flush;
  assign w_push = in_valid & ~flush & (~w_is_full | w_pop);
  assign w_drop = in_valid & ~flush & w_is_full & ~w_pop;

  // ---- write side: memory ----
  // Only written on an accepted push, so in_data outside a pulse never
  // reaches the array.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  // ---- pointers and occupancy ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Pointers are AW bits wide, so wrap modulo DEPTH is implicit.
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      // Push and pop together leave the occupancy unchanged.
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---- sticky overflow ----
  // A drop in the same cycle as clear_status keeps the flag set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clear_status) begin
      r_overflow <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_ERR_COUNT_EN
  logic                 r_err_prev;
  logic [ERR_WIDTH-1:0] r_err_count;
  logic                 w_err_rise;

  function automatic logic [ERR_WIDTH-1:0] sat_inc(input logic [ERR_WIDTH-1:0] v);
    return (&v) ? v : v + ERR_WIDTH'(1);
  endfunction

  // One error episode (a level that stays high) counts exactly once.
  assign w_err_rise = in_error & ~r_err_prev;

  // ---- error episode counter ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err_prev  <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_err_prev <= in_error;
      if (w_err_rise) begin
        // A new edge during clear_status restarts the count at one.
        r_err_count <= clear_status ? ERR_WIDTH'(1) : sat_inc(r_err_count);
      end else if (clear_status) begin
        r_err_count <= '0;
      end
    end
  end

  assign err_count = r_err_count;
`else
  logic w_unused_err;
  assign w_unused_err = in_error;
  assign err_count    = '0;
`endif

  // ---- show-ahead head and status outputs ----
  assign out_valid   = w_not_empty;
  assign out_data    = w_not_empty ? r_mem[r_rd_ptr] : '0;
  assign count       = r_count;
  assign empty       = ~w_not_empty;
  assign full        = w_is_full;
  assign almost_full = (r_count >= C_AFULL);
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AFL   = DEPTH - 2;
  localparam int EW    = 2;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int EMAX  = (1 << EW) - 1;
`ifdef UART_RX_FIFO_ERR_COUNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_error;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          flush;
  logic          clear_status;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          almost_full;
  logic          overflow;
  logic [EW-1:0] err_count;

  uart_rx_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AFULL_LEVEL(AFL),
    .ERR_WIDTH  (EW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_error    (in_error),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .flush       (flush),
    .clear_status(clear_status),
    .count       (count),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .overflow    (overflow),
    .err_count   (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: words held, sticky flag, error-episode tally.
  logic [DW-1:0] exp_q[$];
  bit            m_ovf  = 1'b0;
  bit            m_prev = 1'b0;
  int            m_err  = 0;

  // What the upcoming clock edge is going to do, as predicted by the driver.
  bit            p_rst   = 1'b1;
  bit            p_push  = 1'b0;
  bit            p_drop  = 1'b0;
  bit            p_flush = 1'b0;
  bit            p_clear = 1'b0;
  bit            p_err   = 1'b0;
  logic [DW-1:0] p_word  = '0;
  bit            mon_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update at each active edge.
  task automatic model_step();
    bit rise;
    if (p_rst) begin
      exp_q.delete();
      m_ovf  = 1'b0;
      m_prev = 1'b0;
      m_err  = 0;
    end else begin
      rise   = p_err && !m_prev;
      m_prev = p_err;
      if (p_flush) exp_q.delete();
      else if (p_push) exp_q.push_back(p_word);
      if (p_drop) m_ovf = 1'b1;
      else if (p_clear) m_ovf = 1'b0;
      if (p_clear) m_err = rise ? 1 : 0;
      else if (rise && m_err < EMAX) m_err = m_err + 1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor: samples mid-cycle, pops the scoreboard when the DUT hands a word out.
  initial forever begin
    int n;
    @(negedge clk);
    if (mon_en) begin
      n = exp_q.size();
      chk("count", 32'(count), 32'(n));
      chk("out_valid", 32'(out_valid), 32'(n != 0));
      chk("empty", 32'(empty), 32'(n == 0));
      chk("full", 32'(full), 32'(n == DEPTH));
      chk("almost_full", 32'(almost_full), 32'(n >= AFL));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("err_count", 32'(err_count), ERR_EN ? 32'(m_err) : 32'd0);
      if (n == 0) chk("out_data_idle", 32'(out_data), 32'd0);
      if (out_valid && out_ready) begin
        if (n == 0) begin
          chk("spurious_pop", 32'(out_valid), 32'd0);
        end else begin
          chk("out_data", 32'(out_data), 32'(exp_q[0]));
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Drive one cycle's inputs (called at posedge+2) and predict the edge.
  task automatic drive(input bit iv, input logic [DW-1:0] d, input bit rdy,
                       input bit fl, input bit clr, input bit err, input bit rn);
    bit pop_pred;
    in_valid     = iv;
    in_data      = iv ? d : DW'($urandom);
    out_ready    = rdy;
    flush        = fl;
    clear_status = clr;
    in_error     = err;
    rst_n        = rn;
    pop_pred     = (exp_q.size() != 0) && rdy;
    p_rst        = !rn;
    p_flush      = fl;
    p_clear      = clr;
    p_err        = err;
    p_word       = d;
    p_push       = iv && !fl && ((exp_q.size() < DEPTH) || pop_pred);
    p_drop       = iv && !fl && (exp_q.size() == DEPTH) && !pop_pred;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input bit rdy);
    drive(1'b0, '0, rdy, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    bit errl;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_error = 1'b0;
    out_ready = 1'b0; flush = 1'b0; clear_status = 1'b0;
    @(posedge clk);
    #2;
    mon_en = 1'b1;
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Three words held, then drained in order.
    drive(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Seventeen pushes into sixteen slots, then clear the sticky flag.
    for (int i = 0; i < 17; i++) drive(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(1'b0);

    // Full with a simultaneous push and pop; 3C must come out last.
    drive(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    for (int i = 0; i < 17; i++) idle(1'b1);

    // Five words, then flush with a word arriving in the same cycle.
    for (int i = 0; i < 5; i++) drive(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    idle(1'b1);

    // Five error episodes, each two cycles high.
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    idle(1'b0);

    // Overflow set, drained to seven words, glitch on rst_n, then a real reset.
    for (int i = 0; i < 17; i++) drive(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) idle(1'b1);
    idle(1'b0);
    #3 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    idle(1'b0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);

    // Randomised traffic with occasional flush, clear, error and reset.
    errl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bit rdy;
      if ($urandom_range(0, 4) == 0) errl = !errl;
      rdy = ((i / 300) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      drive(1'($urandom_range(0, 1)), DW'($urandom), rdy,
            ($urandom_range(0, 49) == 0), ($urandom_range(0, 29) == 0),
            errl, ($urandom_range(0, 299) != 0));
    end
    for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
